// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch unit.
//   It fetches words sequentially from instruction memory, one request at a
//   time, and buffers each {pc, instruction} pair in a DEPTH-entry FIFO.
//   A redirect flushes the FIFO and restarts fetch at a new PC.
// Ports:
//   clk, reset          - single clock; asynchronous active-low reset
//   redirect_valid/_pc  - branch/jump redirect request and target
//   imem_req/_addr      - memory request; held stable until imem_ack
//   imem_ack/_rdata     - same-cycle accept with read data
//   instr_valid/_data/_pc, instr_ready - queue head and consumer handshake
module fetch_queue #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_STEP  = 1,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   pc, pc_next;
  logic [ADDR_W-1:0]   flush_addr;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count, count_next;
  logic                push, pop;

  logic [ADDR_W-1:0]   pc_mem    [DEPTH];
  logic [INSTR_W-1:0]  instr_mem [DEPTH];

  // Next-state, FIFO control and request outputs.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    instr_valid = (count != '0);
    // Flush wins over both a push and a pop in the redirect cycle.
    push        = (state == REQ) && imem_ack && !redirect_valid;
    pop         = instr_valid && instr_ready && !redirect_valid;
    count_next  = redirect_valid ? '0 : (count + CW'(push) - CW'(pop));
    imem_req    = (state != IDLE);
    // In FLUSH the abandoned request must keep its original address until
    // acked, while pc already holds the redirect target.
    imem_addr   = (state == FLUSH) ? flush_addr : pc;

    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (push) begin
      pc_next = pc + STEP_C;
    end

    case (state)
      IDLE: begin
        if (redirect_valid || (count_next < DEPTH_C)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          state_next = imem_ack ? REQ : FLUSH;
        end else if (imem_ack) begin
          state_next = (count_next < DEPTH_C) ? REQ : IDLE;
        end
      end
      FLUSH: begin
        // Redirects here only retarget pc; the ack just retires the old request.
        if (imem_ack) begin
          state_next = REQ;
        end
      end
      default: state_next = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= REQ;
      pc         <= RST_PC;
      flush_addr <= RST_PC;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      count <= count_next;
      if ((state == REQ) && redirect_valid && !imem_ack) begin
        flush_addr <= pc;
      end
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end
  end

  // Storage needs no reset: count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

  assign instr_data = instr_mem[rd_ptr];
  assign instr_pc   = pc_mem[rd_ptr];

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (defaults:
// ADDR_W=16, INSTR_W=16, DEPTH=4, PC_STEP=1, RESET_PC=0). Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;

  // Memory model: each word is its address XOR a fixed pattern.
  assign imem_rdata = imem_addr ^ 16'hA5A5;

  always #5 clk = ~clk;

  fetch_queue #(
    .ADDR_W(16), .INSTR_W(16), .DEPTH(4), .PC_STEP(1), .RESET_PC(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc();
    reset          = 1'b0;
    imem_ack       = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    #2;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req",   32'(imem_req),    32'd1);
    chk("rst_addr",  32'(imem_addr),   32'h0000);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;

    // Streaming: ack every cycle, always ready -> pc 0,1,2,... no bubbles.
    do_reset();
    imem_ack = 1'b1; instr_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("seq_valid", 32'(instr_valid), 32'd1);
      chk("seq_pc",    32'(instr_pc),    32'(i - 1));
      chk("seq_data",  32'(instr_data),  32'(16'(i - 1) ^ 16'hA5A5));
      chk("seq_addr",  32'(imem_addr),   32'(i));
    end

    // Back-pressure: 4 acks fill the queue, then requests stop.
    do_reset();
    imem_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("fill_req",  32'(imem_req),  32'd1);
      chk("fill_addr", 32'(imem_addr), 32'(i));
    end
    cyc();
    chk("full_req",   32'(imem_req),    32'd0);
    chk("full_valid", 32'(instr_valid), 32'd1);
    chk("full_pc",    32'(instr_pc),    32'd0);
    cyc();
    chk("full_req2",  32'(imem_req),    32'd0);
    instr_ready = 1'b1;
    cyc();
    chk("resume_req",  32'(imem_req),  32'd1);
    chk("resume_addr", 32'(imem_addr), 32'd4);
    chk("resume_pc",   32'(instr_pc),  32'd1);
    instr_ready = 1'b0; imem_ack = 1'b0;

    // Redirect during an outstanding request, then a second redirect in FLUSH.
    do_reset();
    imem_ack = 1'b1; instr_ready = 1'b1;
    repeat (5) cyc();
    chk("pre_addr",  32'(imem_addr),   32'h0005);
    chk("pre_valid", 32'(instr_valid), 32'd1);
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0080;
    cyc();
    chk("flush_addr0",  32'(imem_addr),   32'h0005);
    chk("flush_req0",   32'(imem_req),    32'd1);
    chk("flush_valid0", 32'(instr_valid), 32'd0);
    redirect_pc = 16'h0100;
    cyc();
    chk("flush_addr1", 32'(imem_addr), 32'h0005);
    redirect_valid = 1'b0;
    cyc();
    chk("flush_addr2", 32'(imem_addr), 32'h0005);
    imem_ack = 1'b1;
    cyc();
    chk("redir_addr",  32'(imem_addr),   32'h0100);
    chk("redir_drop",  32'(instr_valid), 32'd0);
    cyc();
    chk("redir_valid", 32'(instr_valid), 32'd1);
    chk("redir_pc",    32'(instr_pc),    32'h0100);
    chk("redir_data",  32'(instr_data),  32'(16'h0100 ^ 16'hA5A5));
    imem_ack = 1'b0;

    // Redirect coinciding with ack and pop, two entries queued.
    do_reset();
    imem_ack = 1'b1;
    cyc();
    cyc();
    chk("two_pc",   32'(instr_pc),  32'd0);
    chk("two_addr", 32'(imem_addr), 32'd2);
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0040;
    cyc();
    chk("same_valid", 32'(instr_valid), 32'd0);
    chk("same_addr",  32'(imem_addr),   32'h0040);
    chk("same_req",   32'(imem_req),    32'd1);
    redirect_valid = 1'b0;
    cyc();
    chk("same_first_valid", 32'(instr_valid), 32'd1);
    chk("same_first_pc",    32'(instr_pc),    32'h0040);

    // Address wrap: redirect (with ack) to 0xFFFF, then sequential fetch.
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    cyc();
    chk("wrap_addr0",  32'(imem_addr),   32'hFFFF);
    chk("wrap_valid0", 32'(instr_valid), 32'd0);
    redirect_valid = 1'b0;
    cyc();
    chk("wrap_addr1", 32'(imem_addr),   32'h0000);
    chk("wrap_valid", 32'(instr_valid), 32'd1);
    chk("wrap_pc0",   32'(instr_pc),    32'hFFFF);
    cyc();
    chk("wrap_pc1",   32'(instr_pc),    32'h0000);
    chk("wrap_addr2", 32'(imem_addr),   32'h0001);
    imem_ack = 1'b0; instr_ready = 1'b0;

    // Asynchronous reset mid-stream with 3 entries queued.
    do_reset();
    imem_ack = 1'b1;
    repeat (3) cyc();
    chk("ar_valid_pre", 32'(instr_valid), 32'd1);
    chk("ar_pc_pre",    32'(instr_pc),    32'd0);
    imem_ack = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 32'(instr_valid), 32'd0);
    chk("ar_req",   32'(imem_req),    32'd1);
    chk("ar_addr",  32'(imem_addr),   32'h0000);
    cyc();
    chk("ar_hold_valid", 32'(instr_valid), 32'd0);
    reset = 1'b1;
    cyc();
    chk("ar_rel_req",   32'(imem_req),    32'd1);
    chk("ar_rel_addr",  32'(imem_addr),   32'h0000);
    chk("ar_rel_valid", 32'(instr_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDR_W, default 16, width of the program counter and memory address.
REQ-002 Parameter INSTR_W, default 16, width of one instruction word.
REQ-003 Parameter DEPTH, default 4, number of prefetch queue entries; power of two, at least 2.
REQ-004 Parameter PC_STEP, default 1, sequential PC increment.
REQ-005 Parameter RESET_PC, default 0, fetch address after reset.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 redirect_valid  input  1  branch/jump redirect request.
REQ-009 redirect_pc  input  ADDR_W  redirect target address.
REQ-010 imem_req  output  1  instruction memory request.
REQ-011 imem_addr  output  ADDR_W  request address.
REQ-012 imem_ack  input  1  memory accepts the request and returns data in the same cycle.
REQ-013 imem_rdata  input  INSTR_W  instruction word; valid only when imem_ack=1.
REQ-014 instr_valid  output  1  queue head holds a valid instruction.
REQ-015 instr_data  output  INSTR_W  instruction at queue head.
REQ-016 instr_pc  output  ADDR_W  address of the instruction at queue head.
REQ-017 instr_ready  input  1  consumer pops the head when instr_valid=1 and instr_ready=1.

Function
REQ-018 The block SHALL hold the PC, a DEPTH-entry FIFO of {pc, instruction} and a 3-state FSM: IDLE, REQ, FLUSH.
REQ-019 At most one memory request SHALL be outstanding; imem_req and imem_addr SHALL stay stable from assertion until the cycle in which imem_ack=1.
REQ-020 In REQ, imem_req=1 and imem_addr=PC; on ack the word SHALL be written to the FIFO tail with its PC, and PC SHALL become PC+PC_STEP modulo 2^ADDR_W.
REQ-021 On ack in REQ, the FSM SHALL stay in REQ if the post-edge count (count+1-pop) is less than DEPTH, otherwise it SHALL go to IDLE.
REQ-022 In IDLE, imem_req=0; the FSM SHALL enter REQ on the edge after which count is less than DEPTH.
REQ-023 With a zero-wait memory and a consumer that is always ready, one instruction per cycle SHALL be sustained.
REQ-024 Fill latency: ack in cycle t SHALL give instr_valid=1 in cycle t+1 when the FIFO was empty.
REQ-025 A pop and a push in the same cycle SHALL leave count unchanged.
REQ-026 A push SHALL never occur when count=DEPTH, and a pop SHALL never occur when count=0.
REQ-027 Pointers SHALL wrap modulo DEPTH.
REQ-028 If redirect_valid=1 in cycle t, the FIFO SHALL be emptied at the edge, instr_valid SHALL be 0 in cycle t+1, and PC SHALL be set to redirect_pc.
REQ-029 A pop in the redirect cycle SHALL be ignored (flush wins), and an ack in the redirect cycle SHALL NOT be written to the FIFO.
REQ-030 Redirect while in REQ without ack SHALL go to FLUSH; imem_req stays high on the old address, and the acked data is discarded.
REQ-031 In FLUSH, ack SHALL move the FSM to REQ with imem_addr equal to the latest redirect PC.
REQ-032 Redirect in IDLE, or in REQ with ack, SHALL go to REQ with imem_addr=redirect_pc in cycle t+1.
REQ-033 Redirect while in FLUSH SHALL update the PC only and remain in FLUSH.
REQ-034 Consecutive redirects SHALL use the last one.
REQ-035 When instr_valid=0, instr_data and instr_pc SHALL be don't-care.

Reset
REQ-036 While reset=0, the block SHALL asynchronously clear the FIFO (count=0), set PC=RESET_PC, set the FSM to REQ, and drive instr_valid=0.
REQ-037 In the first cycle after reset release, imem_req=1 and imem_addr=RESET_PC.
REQ-038 Reset asserted mid-request SHALL abandon the transaction, and the memory model SHALL drop it.

Verification
REQ-039 Reset release, ack every cycle, instr_ready=1 -> instr_pc sequence 0,1,2,3... starting the cycle after the first ack, one per cycle, with no bubbles.
REQ-040 instr_ready=0, ack every cycle, DEPTH=4 -> exactly 4 acks, then imem_req=0; one pop -> imem_req=1 on the following cycle, addr=4.
REQ-041 Redirect to 0x0100 while a request is outstanding on 0x0005 and the ack is delayed 3 cycles -> imem_addr stays 0x0005 until ack, the word is discarded, then imem_addr=0x0100, and the first instr_pc=0x0100.
REQ-042 Redirect to 0x0040 in the same cycle as an ack and a pop with 2 entries queued -> instr_valid=0 next cycle, imem_addr=0x0040, no stale entry ever appears.
REQ-043 PC=0xFFFF, PC_STEP=1, sequential fetch -> next imem_addr=0x0000, and instr_pc wraps accordingly.
REQ-044 reset=0 pulsed asynchronously mid-stream with 3 entries queued -> instr_valid=0 immediately, then after release imem_addr=RESET_PC.
